display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexed scan controller for a common-anode, active-low seven-segment display bank. It owns one hex-to-seven-segment decoder (`seteSeg`) and shares it among NUM_DIGITS digits by cycling the anode enables. It double-buffers the displayed value behind a valid/ready load handshake so the display never tears mid-frame. It sits between the processor's I/O register (the output-port write) and the board display pins.

## Interface
- NUM_DIGITS, 4, digits scanned (1..8)
- REFRESH_DIV, 50000, clk cycles each digit is lit (>=2)
- GUARD_CYCLES, 2, all-anodes-off cycles before each digit (>=1), anti-ghosting
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit; captured with value_in
- load_valid  in  1  request to load value_in/dp_in
- load_ready  out  1  shadow buffer free; transfer when load_valid && load_ready
- blank_in  in  1  level; 1 = all anodes off while scanning continues
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- dp_n  out  1  decimal point, active-low, registered
- an_n  out  NUM_DIGITS  anode enables, active-low, registered
- frame_done  out  1  one-cycle pulse after the last digit's ON phase

## Operation
- Registers: active (value, dp), shadow (value, dp), pending flag, digit index idx, phase counter cnt, state.
- FSM states: GUARD (all an_n high, seg_n = 7'b1111111, dp_n = 1) and ON (an_n[idx] = 0, seg_n = decode(active nibble idx), dp_n = ~active dp[idx]).
- GUARD -> ON after GUARD_CYCLES cycles; ON -> GUARD after REFRESH_DIV cycles, with idx incremented.
- End of ON with idx = NUM_DIGITS-1: idx wraps to 0, frame_done = 1 for one cycle. If pending, shadow is copied to active and pending is cleared.
- Load: when load_valid && load_ready, value_in/dp_in are written to shadow and pending is set. load_ready = ~pending.
- A load accepted in the frame-boundary cycle goes to shadow and is applied at the next boundary, not the current one.
- blank_in = 1 forces an_n all high on the next cycle. FSM, idx and cnt keep running. frame_done still pulses.
- Widths: cnt is $clog2(max(REFRESH_DIV, GUARD_CYCLES)) bits; idx is max(1, $clog2(NUM_DIGITS)) bits.

## Timing
- Reset values: an_n all 1, seg_n 7'b1111111, dp_n 1, frame_done 0, load_ready 1. Internal state: state GUARD, idx 0, cnt 0, active 0, shadow 0, pending 0.
- Frame length is NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles.
- Outputs lag the state/idx change by one cycle because they are registered.
- load_ready falls the cycle after acceptance. It rises the cycle after the frame boundary that consumed shadow.
- Reset asserted mid-frame returns all outputs to their reset values immediately (async). The pending load is discarded.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking. A digit above the most-significant nonzero nibble of active gets seg_n = 7'b1111111. Its anode and dp are still driven. Digit 0 is never blanked, so 0 displays as "0".
- DISP_LZB_EN undefined: every digit shows its nibble, including leading zeros.

## Structure
- Shared package disp_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the FSM state enum {ST_GUARD, ST_ON}
  - the per-digit nibble width constant NIB_W = 4
- Sub-module: one instance of `seteSeg` (n[3:0] -> s[6:0]). It is fed by the nibble mux on idx, and its output is registered into seg_n. No other sub-modules.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, giving a 20-cycle frame.
- Reset: hold rst_n=0 -> an_n=4'b1111, seg_n=7'b1111111, dp_n=1, load_ready=1, frame_done=0.
- Load and scan: load value_in=16'h12AF, dp_in=4'b0100.
  - Before the boundary, digits show 0 (seg_n=7'b1000000).
  - After frame_done, an_n steps 1110, 1101, 1011, 0111, 4 cycles each, with 1 guard cycle of 1111 between.
  - seg_n = F 0001110, A 0001000, 2 0100100, 1 1111001.
  - dp_n=0 only on digit 2.
- Back-pressure: second load_valid while pending -> load_ready=0, shadow unchanged, old value displayed. It is accepted the cycle after the boundary.
- Boundary load: load accepted in the frame_done cycle -> not displayed until the following frame_done.
- blank_in=1 for 10 cycles -> an_n=1111 throughout. frame_done still pulses at cycle 20. Digit sequence resumes in phase.
- DISP_LZB_EN:
  - 16'h0042 -> digits 3 and 2 get seg_n=1111111, digit 1 gets 0011001, digit 0 gets 0100100.
  - 16'h0000 -> digit 0 gets 1000000, others are blank.
  - Reset mid-frame -> immediate reset values and pending cleared.

Source files
------------

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Constants and types shared by the seven-segment scan controller and its
// decoder.
//   SEG_BLANK : active-low pattern with all segments off
//   NIB_W     : bits per displayed hex digit
//   state_e   : scan FSM states (guard gap / digit lit)
//   max_int   : elaboration-time helper for sizing the phase counter
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int         NIB_W     = 4;

    typedef enum logic {
        ST_GUARD,
        ST_ON
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_seteseg.sv
// -----------------------------------------------------------------------------
// seteSeg
// Hex nibble to seven-segment decoder for a common-anode display.
// Ports:
//   n [3:0] : hex digit in
//   s [6:0] : segments {g,f,e,d,c,b,a}, active-low (0 = segment lit)
// -----------------------------------------------------------------------------
module seteSeg (
    input  logic [3:0] n,
    output logic [6:0] s
);

    always_comb begin
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for a bank of common-anode, active-low
// seven-segment digits. One shared decoder is steered by the lit digit index;
// each digit is preceded by an all-off guard gap to suppress ghosting. The
// displayed value is double-buffered: loads land in a shadow register and are
// promoted to the active register only at a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Ports:
//   clk, rst_n  : system clock (rising edge), asynchronous active-low reset
//   value_in    : hex nibbles, nibble i drives digit i (digit 0 = rightmost)
//   dp_in       : decimal point per digit, 1 = lit
//   load_valid  : load request for value_in/dp_in
//   load_ready  : shadow buffer free; transfer on load_valid && load_ready
//   blank_in    : 1 = all anodes off while scanning keeps running
//   seg_n       : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n        : decimal point, active-low, registered
//   an_n        : anode enables, active-low, registered
//   frame_done  : one-cycle pulse after the last digit's ON phase
//
// Build option: define DISP_LZB_EN for leading-zero blanking (digits above the
// most significant nonzero nibble show no segments; digit 0 always shows).
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NIB_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic                        blank_in,
    output logic [6:0]                  seg_n,
    output logic                        dp_n,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done
);

    localparam int CNT_W = $clog2(max_int(REFRESH_DIV, GUARD_CYCLES));
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    state_e                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              r_idx;
    logic [NIB_W*NUM_DIGITS-1:0]   r_act_val;
    logic [NUM_DIGITS-1:0]         r_act_dp;
    logic [NIB_W*NUM_DIGITS-1:0]   r_sh_val;
    logic [NUM_DIGITS-1:0]         r_sh_dp;
    logic                          r_pending;
    logic [NUM_DIGITS-1:0]         r_an_n;
    logic [6:0]                    r_seg_n;
    logic                          r_dp_n;
    logic                          r_frame_done;

    logic [NIB_W-1:0]              w_nib;
    logic [6:0]                    w_seg;
    logic                          w_lzb;
    logic                          w_frame_end;
    logic                          w_load;

    // Last cycle of the last digit's ON phase: the frame boundary.
    assign w_frame_end = (r_state == ST_ON) && (r_cnt == ON_LAST) && (r_idx == IDX_LAST);
    assign w_load      = load_valid && !r_pending;

    assign w_nib = r_act_val[r_idx*NIB_W +: NIB_W];

    seteSeg u_seg (
        .n (w_nib),
        .s (w_seg)
    );

`ifdef DISP_LZB_EN
    logic [IDX_W-1:0] w_msd;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_act_val[i*NIB_W +: NIB_W] != '0) w_msd = IDX_W'(i);
        end
    end

    // Digit 0 is never above w_msd, so a zero value still shows "0".
    assign w_lzb = (r_idx > w_msd);
`else
    assign w_lzb = 1'b0;
`endif

    // Scan FSM with registered display outputs; outputs reflect the state
    // of the previous cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_GUARD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_an_n       <= '1;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            case (r_state)
                ST_GUARD: begin
                    r_an_n  <= '1;
                    r_seg_n <= SEG_BLANK;
                    r_dp_n  <= 1'b1;
                    if (r_cnt == GUARD_LAST) begin
                        r_state <= ST_ON;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_an_n  <= blank_in ? '1 : ~(AN_ONE << r_idx);
                    r_seg_n <= w_lzb ? SEG_BLANK : w_seg;
                    r_dp_n  <= ~r_act_dp[r_idx];
                    if (r_cnt == ON_LAST) begin
                        r_state <= ST_GUARD;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Double buffer. A load and a promotion never coincide: promotion needs
    // pending set, acceptance needs it clear. A load taken on the boundary
    // edge therefore waits for the next boundary.
    // NOTE: the buffers are plain flops, not a RAM, so they take the async
    // reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_sh_val  <= '0;
            r_sh_dp   <= '0;
            r_pending <= 1'b0;
        end else if (w_frame_end && r_pending) begin
            r_act_val <= r_sh_val;
            r_act_dp  <= r_sh_dp;
            r_pending <= 1'b0;
        end else if (w_load) begin
            r_sh_val  <= value_in;
            r_sh_dp   <= dp_in;
            r_pending <= 1'b1;
        end
    end

    assign load_ready = ~r_pending;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule
